// File: rtl/wheel_motor_driver_if.sv
// Wheel command / H-bridge interface.
// Groups the navigation-side wheel commands and the bridge-side gate drives.
//   L_Ena, R_Ena : wheel enable, active-low (0 = drive)
//   L_Dir, R_Dir : direction, 1 = forward, 0 = reverse
//   L_In1/L_In2, R_In1/R_In2 : H-bridge gate inputs
//   L_Run, R_Run : wheel at full duty
// master = navigation state machine side, slave = motor driver side.
interface wheel_motor_driver_if;
    logic L_Ena;
    logic L_Dir;
    logic R_Ena;
    logic R_Dir;
    logic L_In1;
    logic L_In2;
    logic R_In1;
    logic R_In2;
    logic L_Run;
    logic R_Run;

    modport master (
        output L_Ena, L_Dir, R_Ena, R_Dir,
        input  L_In1, L_In2, R_In1, R_In2, L_Run, R_Run
    );

    modport slave (
        input  L_Ena, L_Dir, R_Ena, R_Dir,
        output L_In1, L_In2, R_In1, R_In2, L_Run, R_Run
    );
endinterface

// File: rtl/wheel_motor_driver.sv
// Two-wheel H-bridge driver: PWM with soft-start duty ramp and dead-time coast
// on direction reversal, one independent channel per wheel (0 = L, 1 = R).
// Ports:
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   wheel   : slave side of wheel_motor_driver_if (Ena/Dir in, In1/In2/Run out)
//
// Per-channel FSM:
//   state | meaning
//   IDLE  | disabled, coast, duty 0
//   RAMP  | soft start, duty +1 every RAMP_DIV PWM periods
//   RUN   | duty held at DUTY_MAX, Run = 1
//   DEAD  | forced coast for DEAD_CYCLES clocks after a direction reversal
module wheel_motor_driver #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_MAX    = 200,
    parameter int RAMP_DIV    = 64,
    parameter int DEAD_CYCLES = 256
) (
    input  logic                 clk_i,
    input  logic                 reset_n,
    wheel_motor_driver_if.slave  wheel
);

    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DEAD = 2'd3;

    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_TOP  = PWM_BITS'(DUTY_MAX);
    localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);

    logic [1:0]          ena_q;
    logic [1:0]          dir_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic                boundary;

    logic [1:0]          state_q    [2];
    logic [1:0]          state_d    [2];
    logic                dir_lat_q  [2];
    logic                dir_lat_d  [2];
    logic [PWM_BITS-1:0] duty_q     [2];
    logic [PWM_BITS-1:0] duty_d     [2];
    logic [PWM_BITS-1:0] duty_act_q [2];
    logic [PWM_BITS-1:0] duty_act_d [2];
    logic [RW-1:0]       ramp_q     [2];
    logic [RW-1:0]       ramp_d     [2];
    logic [DW-1:0]       dead_q     [2];
    logic [DW-1:0]       dead_d     [2];
    logic                drive_d    [2];
    logic                pwm_d      [2];
    logic                in1_q      [2];
    logic                in1_d      [2];
    logic                in2_q      [2];
    logic                in2_d      [2];
    logic                run_q      [2];
    logic                run_d      [2];

    assign pwm_cnt_d = pwm_cnt_q + 1'b1;
    assign boundary  = (pwm_cnt_q == PWM_LAST);

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch]   = state_q[ch];
            dir_lat_d[ch] = dir_lat_q[ch];
            duty_d[ch]    = duty_q[ch];
            ramp_d[ch]    = ramp_q[ch];
            dead_d[ch]    = dead_q[ch];

            if (ena_q[ch]) begin
                state_d[ch] = ST_IDLE;
                duty_d[ch]  = '0;
                ramp_d[ch]  = '0;
                dead_d[ch]  = '0;
            end else begin
                case (state_q[ch])
                    ST_IDLE: begin
                        state_d[ch]   = ST_RAMP;
                        dir_lat_d[ch] = dir_q[ch];
                        duty_d[ch]    = '0;
                        ramp_d[ch]    = '0;
                    end
                    ST_RAMP, ST_RUN: begin
                        if (dir_q[ch] != dir_lat_q[ch]) begin
                            state_d[ch]   = ST_DEAD;
                            dir_lat_d[ch] = dir_q[ch];
                            duty_d[ch]    = '0;
                            ramp_d[ch]    = '0;
                            dead_d[ch]    = '0;
                        end else if (state_q[ch] == ST_RUN) begin
                            duty_d[ch] = DUTY_TOP;
                        end else if (duty_q[ch] == DUTY_TOP) begin
                            // checked before the step so duty saturates and never wraps
                            state_d[ch] = ST_RUN;
                        end else if (boundary) begin
                            if (ramp_q[ch] == RAMP_LAST) begin
                                ramp_d[ch] = '0;
                                duty_d[ch] = duty_q[ch] + 1'b1;
                            end else begin
                                ramp_d[ch] = ramp_q[ch] + 1'b1;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (dir_q[ch] != dir_lat_q[ch]) begin
                            dir_lat_d[ch] = dir_q[ch];
                            dead_d[ch]    = '0;
                        end else if (dead_q[ch] == DEAD_LAST) begin
                            state_d[ch] = ST_RAMP;
                            dead_d[ch]  = '0;
                            ramp_d[ch]  = '0;
                        end else begin
                            dead_d[ch] = dead_q[ch] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[ch] = ST_IDLE;
                        duty_d[ch]  = '0;
                    end
                endcase
            end

            // Outputs are computed from next-state values so the registered
            // gate drives and Run line up with the registered state.
            drive_d[ch] = (state_d[ch] == ST_RAMP) || (state_d[ch] == ST_RUN);

            // Clearing the active duty while coasting keeps a new ramp from
            // briefly driving at the duty left over from before the coast.
            if (!drive_d[ch]) begin
                duty_act_d[ch] = '0;
            end else if (boundary) begin
                duty_act_d[ch] = duty_q[ch];
            end else begin
                duty_act_d[ch] = duty_act_q[ch];
            end

            pwm_d[ch] = (pwm_cnt_d < duty_act_d[ch]);
            in1_d[ch] = drive_d[ch] &&  dir_lat_d[ch] && pwm_d[ch];
            in2_d[ch] = drive_d[ch] && !dir_lat_d[ch] && pwm_d[ch];
            run_d[ch] = (state_d[ch] == ST_RUN);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            ena_q     <= 2'b11;
            dir_q     <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch]    <= ST_IDLE;
                dir_lat_q[ch]  <= 1'b0;
                duty_q[ch]     <= '0;
                duty_act_q[ch] <= '0;
                ramp_q[ch]     <= '0;
                dead_q[ch]     <= '0;
                in1_q[ch]      <= 1'b0;
                in2_q[ch]      <= 1'b0;
                run_q[ch]      <= 1'b0;
            end
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            ena_q     <= {wheel.R_Ena, wheel.L_Ena};
            dir_q     <= {wheel.R_Dir, wheel.L_Dir};
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch]    <= state_d[ch];
                dir_lat_q[ch]  <= dir_lat_d[ch];
                duty_q[ch]     <= duty_d[ch];
                duty_act_q[ch] <= duty_act_d[ch];
                ramp_q[ch]     <= ramp_d[ch];
                dead_q[ch]     <= dead_d[ch];
                in1_q[ch]      <= in1_d[ch];
                in2_q[ch]      <= in2_d[ch];
                run_q[ch]      <= run_d[ch];
            end
        end
    end

    assign wheel.L_In1 = in1_q[0];
    assign wheel.L_In2 = in2_q[0];
    assign wheel.L_Run = run_q[0];
    assign wheel.R_In1 = in1_q[1];
    assign wheel.R_In2 = in2_q[1];
    assign wheel.R_Run = run_q[1];

endmodule

// File: tb/tb_wheel_motor_driver.sv
// Testbench for wheel_motor_driver: vector table, directed corner-case
// sequences and randomized commands, all checked against a reference model.
module tb_wheel_motor_driver;

    localparam int PWM_BITS    = 4;
    localparam int DUTY_MAX    = 8;
    localparam int RAMP_DIV    = 2;
    localparam int DEAD_CYCLES = 5;
    localparam int PERIOD      = 1 << PWM_BITS;

    logic clk_i   = 1'b0;
    logic reset_n = 1'b0;

    wheel_motor_driver_if wif ();

    wheel_motor_driver #(
        .PWM_BITS    (PWM_BITS),
        .DUTY_MAX    (DUTY_MAX),
        .RAMP_DIV    (RAMP_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .wheel   (wif)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A wheel is either off, coasting with some clocks of dead time left, or
    // driving; while driving its duty is min(DUTY_MAX, boundaries / RAMP_DIV)
    // where boundaries counts PWM period ends since the ramp (re)started.
    bit m_on    [2];
    int m_dead  [2];
    bit m_dir   [2];
    int m_bnd   [2];
    int m_da    [2];
    bit m_run   [2];
    bit m_in1   [2];
    bit m_in2   [2];
    bit m_ena_q [2];
    bit m_dir_q [2];
    int m_pwm;
    bit m_edge_bnd;
    int m_pwm_next;
    int m_duty_now;
    bit m_drive;

    function automatic int model_duty(input int ch);
        int d;
        if (!m_on[ch] || m_dead[ch] != 0) return 0;
        d = m_bnd[ch] / RAMP_DIV;
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            m_pwm = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_on[ch] = 0; m_dead[ch] = 0; m_dir[ch] = 0; m_bnd[ch] = 0;
                m_da[ch] = 0; m_run[ch] = 0; m_in1[ch] = 0; m_in2[ch] = 0;
                m_ena_q[ch] = 1; m_dir_q[ch] = 0;
            end
        end else begin
            m_edge_bnd = (m_pwm == PERIOD - 1);
            m_pwm_next = (m_pwm + 1) % PERIOD;
            for (int ch = 0; ch < 2; ch++) begin
                m_duty_now = model_duty(ch);
                m_run[ch] = m_on[ch] && m_dead[ch] == 0 && m_duty_now == DUTY_MAX &&
                            !m_ena_q[ch] && m_dir_q[ch] == m_dir[ch];
                if (m_ena_q[ch]) begin
                    m_on[ch] = 0; m_dead[ch] = 0; m_bnd[ch] = 0;
                end else if (!m_on[ch]) begin
                    m_on[ch] = 1; m_dir[ch] = m_dir_q[ch]; m_bnd[ch] = 0; m_dead[ch] = 0;
                end else if (m_dir_q[ch] != m_dir[ch]) begin
                    m_dir[ch] = m_dir_q[ch]; m_dead[ch] = DEAD_CYCLES; m_bnd[ch] = 0;
                end else if (m_dead[ch] > 0) begin
                    m_dead[ch]--; m_bnd[ch] = 0;
                end else if (m_edge_bnd && m_bnd[ch] < 100000) begin
                    m_bnd[ch]++;
                end
                m_drive = m_on[ch] && m_dead[ch] == 0;
                if (!m_drive) m_da[ch] = 0;
                else if (m_edge_bnd) m_da[ch] = m_duty_now;
                m_in1[ch] = m_drive &&  m_dir[ch] && (m_pwm_next < m_da[ch]);
                m_in2[ch] = m_drive && !m_dir[ch] && (m_pwm_next < m_da[ch]);
            end
            m_pwm = m_pwm_next;
            m_ena_q[0] = wif.L_Ena; m_dir_q[0] = wif.L_Dir;
            m_ena_q[1] = wif.R_Ena; m_dir_q[1] = wif.R_Dir;
        end
    end

    always @(negedge clk_i) begin
        if (reset_n) begin
            check("sb_L_In1", wif.L_In1, m_in1[0]);
            check("sb_L_In2", wif.L_In2, m_in2[0]);
            check("sb_L_Run", wif.L_Run, m_run[0]);
            check("sb_R_In1", wif.R_In1, m_in1[1]);
            check("sb_R_In2", wif.R_In2, m_in2[1]);
            check("sb_R_Run", wif.R_Run, m_run[1]);
            check("L_in_overlap", wif.L_In1 & wif.L_In2, 0);
            check("R_in_overlap", wif.R_In1 & wif.R_In2, 0);
        end
    end

    // ---------------- helpers ----------------
    task automatic count_pulses(input int n, output int l1, output int l2,
                                output int r1, output int r2);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            l1 += int'(wif.L_In1); l2 += int'(wif.L_In2);
            r1 += int'(wif.R_In1); r2 += int'(wif.R_In2);
        end
    endtask

    task automatic wait_run(input bit right, input string name);
        int n;
        n = 0;
        while ((right ? wif.R_Run : wif.L_Run) == 1'b0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check(name, int'(right ? wif.R_Run : wif.L_Run), 1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({wif.L_In1, wif.L_In2, wif.L_Run, wif.R_In1, wif.R_In2, wif.R_Run}), 0);
    endtask

    typedef struct {
        bit l_ena; bit l_dir; bit r_ena; bit r_dir;
        int cycles;
        bit exp_l_run; bit exp_r_run;
    } vec_t;

    vec_t vecs [11];
    int l1, l2, r1, r2, acc;
    int lflip, rflip;

    initial begin
        vecs[0]  = '{1, 1, 1, 1,  20, 0, 0};
        vecs[1]  = '{0, 1, 1, 1, 200, 0, 0};
        vecs[2]  = '{0, 1, 1, 1, 100, 1, 0};
        vecs[3]  = '{0, 1, 0, 0, 150, 1, 0};
        vecs[4]  = '{0, 1, 0, 0, 150, 1, 1};
        vecs[5]  = '{0, 0, 0, 0,   3, 0, 1};
        vecs[6]  = '{1, 0, 0, 0,   3, 0, 1};
        vecs[7]  = '{1, 0, 0, 1,   3, 0, 0};
        vecs[8]  = '{0, 1, 0, 1, 200, 0, 0};
        vecs[9]  = '{0, 1, 0, 1, 150, 1, 1};
        vecs[10] = '{1, 1, 1, 1,   3, 0, 0};

        wif.L_Ena = 1; wif.L_Dir = 1; wif.R_Ena = 1; wif.R_Dir = 1;
        reset_n = 0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset_outputs");
        reset_n = 1;

        // ---- table-driven phases ----
        for (int v = 0; v < 11; v++) begin
            wif.L_Ena = vecs[v].l_ena; wif.L_Dir = vecs[v].l_dir;
            wif.R_Ena = vecs[v].r_ena; wif.R_Dir = vecs[v].r_dir;
            repeat (vecs[v].cycles) @(negedge clk_i);
            check($sformatf("vec%0d_L_Run", v), wif.L_Run, vecs[v].exp_l_run);
            check($sformatf("vec%0d_R_Run", v), wif.R_Run, vecs[v].exp_r_run);
        end

        // ---- soft start forward, then full duty ----
        wif.L_Ena = 0; wif.L_Dir = 1;
        count_pulses(32, l1, l2, r1, r2);
        check("ramp_start_L_In1_zero", l1, 0);
        wait_run(0, "ramp_fwd_reaches_run");
        repeat (17) @(negedge clk_i);
        count_pulses(PERIOD, l1, l2, r1, r2);
        check("run_fwd_L_In1_high", l1, DUTY_MAX);
        check("run_fwd_L_In2_low", l2, 0);

        // ---- reversal in RUN: dead coast then reverse ramp ----
        wif.L_Dir = 0;
        acc = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk_i);
            if (i == 2) check("reverse_L_Run_drop", wif.L_Run, 0);
            if (i >= 2) acc += int'(wif.L_In1 | wif.L_In2);
        end
        check("reverse_dead_coast", acc, 0);
        wait_run(0, "ramp_rev_reaches_run");
        repeat (17) @(negedge clk_i);
        count_pulses(PERIOD, l1, l2, r1, r2);
        check("run_rev_L_In2_high", l2, DUTY_MAX);
        check("run_rev_L_In1_low", l1, 0);

        // ---- second reversal inside dead time restarts it ----
        wif.L_Dir = 1;
        repeat (5) @(negedge clk_i);
        wif.L_Dir = 0;
        count_pulses(10, l1, l2, r1, r2);
        check("dead_retoggle_coast", l1 + l2, 0);
        wait_run(0, "dead_retoggle_reaches_run");
        repeat (17) @(negedge clk_i);
        count_pulses(PERIOD, l1, l2, r1, r2);
        check("dead_retoggle_newest_dir", l2, DUTY_MAX);
        check("dead_retoggle_old_dir_off", l1, 0);
        wif.L_Ena = 1;
        repeat (3) @(negedge clk_i);

        // ---- disable mid-ramp ----
        wif.R_Ena = 0; wif.R_Dir = 1;
        repeat (150) @(negedge clk_i);
        count_pulses(PERIOD, l1, l2, r1, r2);
        check("midramp_R_pulsing", int'(r1 > 0 && r1 < DUTY_MAX), 1);
        wif.R_Ena = 1;
        repeat (2) @(negedge clk_i);
        check("disable_R_In1", wif.R_In1, 0);
        check("disable_R_In2", wif.R_In2, 0);
        check("disable_R_Run", wif.R_Run, 0);
        wif.R_Ena = 0;
        count_pulses(32, l1, l2, r1, r2);
        check("reenable_R_restart", r1 + r2, 0);
        wait_run(1, "reenable_R_reaches_run");
        wif.R_Ena = 1;
        repeat (3) @(negedge clk_i);

        // ---- both wheels, opposite directions, same start ----
        wif.L_Ena = 0; wif.L_Dir = 1; wif.R_Ena = 0; wif.R_Dir = 0;
        acc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (wif.L_In1 != wif.R_In2 || wif.L_Run != wif.R_Run ||
                wif.L_In2 || wif.R_In1) acc++;
        end
        check("sym_ramp_mismatch_cycles", acc, 0);
        check("sym_both_run", int'(wif.L_Run & wif.R_Run), 1);

        // ---- asynchronous reset mid-RUN ----
        @(posedge clk_i);
        #2 reset_n = 0;
        #1 check_all_zero("async_reset_outputs");
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n = 1;
        count_pulses(32, l1, l2, r1, r2);
        check("post_reset_restart", l1 + r2, 0);
        check("post_reset_no_run", int'(wif.L_Run | wif.R_Run), 0);
        wait_run(0, "post_reset_L_run");

        // ---- randomized commands against the model ----
        lflip = 0; rflip = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_i);
            if (wif.L_Ena) begin
                if ($urandom_range(0, 99) < 5) wif.L_Ena = 0;
            end else if ($urandom_range(0, 999) < 2) wif.L_Ena = 1;
            if (wif.R_Ena) begin
                if ($urandom_range(0, 99) < 5) wif.R_Ena = 0;
            end else if ($urandom_range(0, 999) < 2) wif.R_Ena = 1;
            if (lflip == 1) wif.L_Dir = ~wif.L_Dir;
            if (lflip > 0) lflip--;
            else if ($urandom_range(0, 999) < 4) begin
                wif.L_Dir = ~wif.L_Dir;
                if ($urandom_range(0, 2) == 0) lflip = $urandom_range(1, 8);
            end
            if (rflip == 1) wif.R_Dir = ~wif.R_Dir;
            if (rflip > 0) rflip--;
            else if ($urandom_range(0, 999) < 4) begin
                wif.R_Dir = ~wif.R_Dir;
                if ($urandom_range(0, 2) == 0) rflip = $urandom_range(1, 8);
            end
            if ($urandom_range(0, 1999) == 0) begin
                #3 reset_n = 0;
                #1 check_all_zero("rand_async_reset");
                @(negedge clk_i);
                reset_n = 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wheel_motor_driver.md
Name: wheel_motor_driver

Overview:
- Consumer of the wheel command interface (L_Ena/L_Dir/R_Ena/R_Dir) driven by the bumper state machine; converts each wheel's enable/direction command into H-bridge gate inputs.
- Per wheel: PWM generation, soft-start duty ramp, and dead-time coast on direction reversal.
- Sits between the navigation state machine and the two H-bridge ICs; all logic is in one clock domain.

Parameters:
- PWM_BITS, 8, width of the shared PWM counter; PWM period = 2^PWM_BITS clocks.
- DUTY_MAX, 200, final duty in counts; must be <= 2^PWM_BITS-1.
- RAMP_DIV, 64, PWM periods per +1 duty step during ramp; >= 1.
- DEAD_CYCLES, 256, clocks of forced coast on direction reversal; >= 1.

Ports:
- clk_i  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- L_Ena  in  1  left wheel enable, active-low (0 = drive)
- L_Dir  in  1  left direction, 1 = forward, 0 = reverse
- R_Ena  in  1  right wheel enable, active-low
- R_Dir  in  1  right direction, 1 = forward, 0 = reverse
- L_In1  out  1  left H-bridge input 1
- L_In2  out  1  left H-bridge input 2
- R_In1  out  1  right H-bridge input 1
- R_In2  out  1  right H-bridge input 2
- L_Run  out  1  left wheel at full duty (state RUN)
- R_Run  out  1  right wheel at full duty

Behaviour:
- Clock and reset: one clock, clk_i. reset_n is asynchronous and active-low. While reset_n is low: all outputs 0, pwm_cnt = 0, both channels in IDLE, duty = 0, ramp and dead counters = 0.
- Input register: Ena/Dir are registered once (1-cycle latency). All decisions below use the registered values.
- PWM counter:
  - pwm_cnt is free-running 0..2^PWM_BITS-1, wraps to 0 and is shared by both wheels.
  - "Period boundary" = the cycle in which pwm_cnt == 2^PWM_BITS-1.
- Drive output:
  - pwm = (pwm_cnt < duty_active), where duty_active is reloaded from duty only at the period boundary. This gives glitch-free duty changes.
  - Dir=1 -> In1 = pwm, In2 = 0. Dir=0 -> In1 = 0, In2 = pwm.
  - In IDLE and DEAD, In1 = In2 = 0 (coast).
  - Outputs are registered. In1 and In2 are never 1 in the same cycle.
- Per-channel FSM (identical and independent for L and R):
  - IDLE:
    - duty = 0.
    - Registered Ena == 0 -> latch dir, go to RAMP.
  - RAMP:
    - ramp_cnt counts period boundaries. On reaching RAMP_DIV: ramp_cnt = 0, duty += 1.
    - duty == DUTY_MAX -> go to RUN.
  - RUN:
    - duty held at DUTY_MAX, Run output = 1.
  - DEAD:
    - Output coast, duty = 0, dead_cnt counts clocks.
    - dead_cnt == DEAD_CYCLES-1 -> go to RAMP with the latched new dir.
- Transition priority (highest first):
  - Registered Ena == 1 in any state -> IDLE next cycle. duty, ramp_cnt and dead_cnt are cleared, outputs coast.
  - Dir differs from latched dir in RAMP or RUN -> DEAD. Latch the new dir, duty = 0, dead_cnt = 0.
  - Dir change while in DEAD -> latch the new dir and restart dead_cnt at 0.
  - Dir change while in IDLE -> no dead time; the dir is simply latched on entry to RAMP.
- Boundaries:
  - Duty saturates at DUTY_MAX and never wraps.
  - DUTY_MAX = 0 -> RAMP exits to RUN immediately, outputs stay 0.
  - L and R events in the same cycle are handled independently.
  - Reset asserted mid-ramp or mid-dead forces all outputs to 0 asynchronously.
- Run output: Run = 1 only in RUN. Registered, so it is coincident with the state.

Test Plan (bench parameters: PWM_BITS=4, DUTY_MAX=8, RAMP_DIV=2, DEAD_CYCLES=5):
- Reset, then L_Ena=0, L_Dir=1 held -> after the first boundary L_In1 high 0 clocks per 16-clock period, then 1 clock per period after 2 periods, rising by +1 every 2 periods. L_Run = 1 once duty = 8 (after 16 periods). Thereafter L_In1 is high 8 of 16 clocks and L_In2 = 0 throughout.
- In RUN, toggle L_Dir to 0 -> L_In1 = L_In2 = 0 for exactly 5 clocks (DEAD) and L_Run drops. Then RAMP restarts from duty 0 with L_In2 pulsing and L_In1 = 0.
- During DEAD, toggle L_Dir again at dead_cnt = 3 -> coast extends to 5 full clocks after the second toggle, then the ramp resumes in the newest direction.
- Mid-ramp (duty = 4), set R_Ena=1 -> R_In1 = R_In2 = 0 within 2 clocks and R_Run = 0. Re-enable -> ramp restarts from duty 0.
- Drive L forward and R reverse simultaneously -> both channels ramp identically in time, and In1 & In2 is never 1 on either wheel.
- Assert reset_n = 0 mid-RUN for 1 clock, asynchronously -> all six outputs are 0 in the same cycle. After release, with Ena still 0, the ramp restarts from duty 0.
